// File: rtl/gg_seq_pkg.sv
// Shared types and constants for the macroblock sequencer.
package gg_seq_pkg;

    localparam logic [2:0] CIDX_LUMA   = 3'd0;
    localparam logic [2:0] CIDX_ACLUMA = 3'd1;
    localparam logic [2:0] CIDX_CB     = 3'd2;
    localparam logic [2:0] CIDX_CR     = 3'd3;
    localparam logic [2:0] CIDX_DCCB   = 3'd4;
    localparam logic [2:0] CIDX_DCCR   = 3'd5;
    localparam logic [2:0] CIDX_DCY    = 3'd6;

    localparam int SEQ_LEN_I16 = 27;
    localparam int SEQ_LEN_I4  = 26;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [2:0] cidx;
        logic [3:0] bidx;
    } blk_tag_t;

    // Block at position idx of the H.264 MB order. The I16 order is the
    // 4x4 order shifted by one slot to make room for the leading DC-Y block.
    function automatic blk_tag_t seq_entry(input logic i16, input logic [4:0] idx);
        blk_tag_t   t;
        logic [4:0] pos;
        t.cidx = CIDX_LUMA;
        t.bidx = 4'd0;
        pos    = i16 ? (idx - 5'd1) : idx;
        if (i16 && (idx == 5'd0)) begin
            t.cidx = CIDX_DCY;
        end else if (pos < 5'd16) begin
            t.cidx = i16 ? CIDX_ACLUMA : CIDX_LUMA;
            t.bidx = pos[3:0];
        end else if (pos == 5'd16) begin
            t.cidx = CIDX_DCCB;
        end else if (pos == 5'd17) begin
            t.cidx = CIDX_DCCR;
        end else if (pos < 5'd22) begin
            t.cidx = CIDX_CB;
            t.bidx = 4'(pos - 5'd18);
        end else begin
            t.cidx = CIDX_CR;
            t.bidx = 4'(pos - 5'd22);
        end
        return t;
    endfunction

endpackage

// File: rtl/gg_seq_tag_fifo.sv
// Tag FIFO: remembers which block each in-flight result belongs to.
// Overflow is prevented upstream by the pending-count ceiling.
module gg_seq_tag_fifo
    import gg_seq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  logic     pop,
    input  blk_tag_t wr_tag,
    output blk_tag_t rd_tag
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    blk_tag_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Pointer advance on push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    // Tag storage, no reset needed: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_tag;
    end

    assign rd_tag = mem[rd_ptr];

endmodule

// File: rtl/gg_mb_sequencer.sv
// Macroblock sequencer: issues the per-MB block order to the 4x4 datapath and
// folds the returning per-block results into MB bits, CBP and overflow.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | mb_ready high, waiting for an MB command
//   ST_ISSUE | presenting sequence entries, one per blk handshake
//   ST_DRAIN | all blocks issued, waiting for outstanding results
//   ST_DONE  | one-cycle mb_done pulse, accumulators valid
module gg_mb_sequencer
    import gg_seq_pkg::*;
#(
    parameter int LATENCY   = 2,
    parameter int ISSUE_GAP = 1,
    parameter int MAX_PEND  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mb_valid,
    output logic        mb_ready,
    input  logic        mb_i16,
    input  logic [7:0]  mb_x,
    input  logic [7:0]  mb_y,
    output logic        blk_valid,
    input  logic        blk_ready,
    output logic [2:0]  blk_cidx,
    output logic [3:0]  blk_bidx,
    output logic        abv_out_of_pic,
    output logic        left_out_of_pic,
    input  logic        res_valid,
    input  logic [8:0]  res_bitcount,
    input  logic [4:0]  res_num_coeff,
    input  logic [6:0]  res_overflow,
    output logic        mb_done,
    output logic [13:0] mb_bits,
    output logic [5:0]  mb_cbp,
    output logic [6:0]  mb_overflow,
    output logic        err_unexpected
);

    localparam int PW = $clog2(MAX_PEND + 1);
    localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

    if ((LATENCY < 1) || (LATENCY > 8) || (ISSUE_GAP < 1) ||
        (MAX_PEND < ((LATENCY + ISSUE_GAP - 1) / ISSUE_GAP) + 1)) begin : g_param_check
        $error("gg_mb_sequencer: illegal LATENCY/ISSUE_GAP/MAX_PEND combination");
    end

    seq_state_t     state, state_nxt;
    logic [4:0]     seq_idx;
    logic           i16_q;
    logic [GW-1:0]  gap_cnt;
    logic [PW-1:0]  pend_cnt, pend_nxt;
    logic [3:0]     luma_nz;
    logic           chroma_ac, chroma_dc;
    blk_tag_t       cur_tag, res_tag;
    logic [4:0]     seq_last;
    logic           issue, accept, res_hit, res_stray;
    logic [14:0]    bits_sum;

    assign cur_tag   = seq_entry(i16_q, seq_idx);
    assign seq_last  = i16_q ? 5'(SEQ_LEN_I16 - 1) : 5'(SEQ_LEN_I4 - 1);
    assign issue     = blk_valid && blk_ready;
    assign accept    = mb_valid && mb_ready;
    assign res_hit   = res_valid && (pend_cnt != '0);
    assign res_stray = res_valid && (pend_cnt == '0);
    assign bits_sum  = {1'b0, mb_bits} + 15'(res_bitcount);
    assign mb_cbp    = {(chroma_ac ? 2'd2 : (chroma_dc ? 2'd1 : 2'd0)), luma_nz};

    // Outstanding-result count after this cycle's issue/result.
    always_comb begin
        pend_nxt = pend_cnt;
        if (issue && !res_hit)      pend_nxt = pend_cnt + PW'(1);
        else if (!issue && res_hit) pend_nxt = pend_cnt - PW'(1);
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        mb_ready  = 1'b0;
        mb_done   = 1'b0;
        blk_valid = 1'b0;
        blk_cidx  = 3'd0;
        blk_bidx  = 4'd0;
        unique case (state)
            ST_IDLE: begin
                mb_ready = 1'b1;
                if (mb_valid) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                blk_valid = (gap_cnt == '0) && (pend_cnt != PW'(MAX_PEND));
                blk_cidx  = cur_tag.cidx;
                blk_bidx  = cur_tag.bidx;
                if (issue && (seq_idx == seq_last)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pend_nxt == '0) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                mb_done   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Sequence position, counters, MB latches and result accumulation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_idx         <= 5'd0;
            i16_q           <= 1'b0;
            gap_cnt         <= '0;
            pend_cnt        <= '0;
            abv_out_of_pic  <= 1'b0;
            left_out_of_pic <= 1'b0;
            mb_bits         <= 14'd0;
            luma_nz         <= 4'd0;
            chroma_ac       <= 1'b0;
            chroma_dc       <= 1'b0;
            mb_overflow     <= 7'd0;
            err_unexpected  <= 1'b0;
        end else begin
            pend_cnt <= pend_nxt;

            if (issue)                gap_cnt <= GW'(ISSUE_GAP - 1);
            else if (gap_cnt != '0)   gap_cnt <= gap_cnt - GW'(1);

            if (accept) begin
                i16_q           <= mb_i16;
                abv_out_of_pic  <= (mb_y == 8'd0);
                left_out_of_pic <= (mb_x == 8'd0);
                seq_idx         <= 5'd0;
                mb_bits         <= 14'd0;
                luma_nz         <= 4'd0;
                chroma_ac       <= 1'b0;
                chroma_dc       <= 1'b0;
                mb_overflow     <= 7'd0;
                err_unexpected  <= 1'b0;
            end else if (issue && (seq_idx != seq_last)) begin
                seq_idx <= seq_idx + 5'd1;
            end

            // A stray strobe in the accept cycle still counts as an error.
            if (res_stray) err_unexpected <= 1'b1;

            if (res_hit) begin
                mb_bits     <= bits_sum[14] ? 14'h3FFF : bits_sum[13:0];
                mb_overflow <= mb_overflow | res_overflow;
                if (res_num_coeff != 5'd0) begin
                    case (res_tag.cidx)
                        CIDX_LUMA:            luma_nz[2'(res_tag.bidx >> 2)] <= 1'b1;
                        CIDX_ACLUMA:          luma_nz   <= 4'hF;
                        CIDX_CB, CIDX_CR:     chroma_ac <= 1'b1;
                        CIDX_DCCB, CIDX_DCCR: chroma_dc <= 1'b1;
                        default:              ;
                    endcase
                end
            end
        end
    end

    gg_seq_tag_fifo #(
        .DEPTH (MAX_PEND)
    ) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (issue),
        .pop     (res_hit),
        .wr_tag  (cur_tag),
        .rd_tag  (res_tag)
    );

endmodule
